datapath_param: RTL and testbench

Parametrised successor to the single-bus CPU datapath. It holds a width- and depth-configurable general register file, HI/LO, Y, Z (hi/lo), PC, IR, MAR/MDR, in/out ports and the CON FF around one shared bus. Memory access goes through a wait-state-tolerant request/acknowledge handshake rather than fixed single-cycle RAM. The block sits between the control unit (which drives the one-hot control strobes) and the external ALU and memory.

---
 rtl/dp_pkg.sv | 17 +
 rtl/datapath_param_if.sv | 11 +
 rtl/dp_mem_ctrl.sv | 29 ++
 rtl/datapath_param.sv | 133 +++++++++++++
 tb/tb_datapath_param.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared types and IR field-offset helpers for datapath_param
package dp_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_e;
  typedef enum logic [1:0] {C2_ZERO = 2'b00, C2_NZ = 2'b01, C2_POS = 2'b10, C2_NEG = 2'b11} c2_e;
  function automatic int ra_lo(input int dw, input int rw);
    return dw - 5 - rw;
  endfunction
  function automatic int rb_lo(input int dw, input int rw);
    return dw - 5 - 2 * rw;
  endfunction
  function automatic int rc_lo(input int dw, input int rw);
    return dw - 5 - 3 * rw;
  endfunction
  function automatic int c_hi(input int dw, input int rw);
    return dw - 6 - 2 * rw;
  endfunction
endpackage

// File: rtl/datapath_param_if.sv
// datapath_param_if: request/acknowledge memory port between datapath and memory
interface datapath_param_if #(parameter int DW = 32, parameter int AW = 9);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  modport master (output mem_addr, mem_wdata, mem_req, mem_we, input mem_rdata, mem_ack);
  modport slave  (input mem_addr, mem_wdata, mem_req, mem_we, output mem_rdata, mem_ack);
endinterface

// File: rtl/dp_mem_ctrl.sv
// dp_mem_ctrl: wait-state tolerant memory handshake FSM with MDR capture strobe
module dp_mem_ctrl
  import dp_pkg::*;
(
  input  logic clock,
  input  logic clear,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_we,
  output logic busy,
  output logic mdr_cap
);
  mem_state_e state_q, state_d;
  // next state and handshake outputs; read wins when both pulses arrive together
  always_comb begin
    state_d = state_q == IDLE ? (mem_rd ? RD_WAIT : mem_wr ? WR_WAIT : IDLE)
                              : (mem_ack ? IDLE : state_q);
    mem_req = state_q != IDLE;
    mem_we  = state_q == WR_WAIT;
    busy    = (state_q != IDLE) | mem_rd | mem_wr;
    mdr_cap = (state_q == RD_WAIT) & mem_ack;
  end
  // state register; clear aborts any outstanding transaction immediately
  always_ff @(posedge clock or posedge clear)
    if (clear) state_q <= IDLE;
    else state_q <= state_d;
endmodule

// File: rtl/datapath_param.sv
// datapath_param: single-bus CPU datapath with parametrised register file and handshaked memory
module datapath_param
  import dp_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 16,
  parameter int AW   = 9
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          gra, grb, grc, rin, rout, baout,
  input  logic          pcout, zhiout, zloout, hiout, loout, mdrout, inportout, cout,
  input  logic          pcin, inc_pc, irin, yin, zin, hiin, loin, marin, mdrin, outportin, conin,
  input  logic          mem_rd, mem_wr,
  input  logic [DW-1:0] inport_data,
  output logic [DW-1:0] outport_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_lo,
  input  logic [DW-1:0] alu_hi,
  datapath_param_if.master mem,
  output logic          busy,
  output logic          con_ff,
  output logic [DW-1:0] ir,
  output logic          bus_conflict
);
  localparam int RW    = $clog2(NREG);
  localparam int RA_LO = ra_lo(DW, RW);
  localparam int RB_LO = rb_lo(DW, RW);
  localparam int RC_LO = rc_lo(DW, RW);
  localparam int C_HI  = c_hi(DW, RW);
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d, y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [DW-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, out_q, out_d;
  logic [AW-1:0] mar_q, mar_d;
  logic          con_q, con_d;
  logic [DW-1:0] r_val [NREG];
  logic [RW-1:0] sel;
  logic          reg_en, mdr_cap, cond;
  logic [DW-1:0] reg_bus, c_val, bus_or, bus;
  logic [8:0]    srcs;
  c2_e           c2;
  dp_mem_ctrl u_mem_ctrl (
    .clock   (clock),
    .clear   (clear),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .mem_ack (mem.mem_ack),
    .mem_req (mem.mem_req),
    .mem_we  (mem.mem_we),
    .busy    (busy),
    .mdr_cap (mdr_cap)
  );
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic [DW-1:0] r_q, r_d;
    // load this register from the bus when it is the selected write target
    always_comb r_d = (rin && sel == RW'(i)) ? bus : r_q;
    // register storage
    always_ff @(posedge clock or posedge clear)
      if (clear) r_q <= '0;
      else r_q <= r_d;
    assign r_val[i] = r_q;
  end
  // register select, bus source mux and conflict detection
  always_comb begin
    sel     = ({RW{gra}} & ir_q[RA_LO +: RW]) | ({RW{grb}} & ir_q[RB_LO +: RW])
            | ({RW{grc}} & ir_q[RC_LO +: RW]);
    reg_en  = rout | baout;
    reg_bus = (baout && sel == '0) ? '0 : r_val[sel];
    c_val   = {{(DW-C_HI-1){ir_q[C_HI]}}, ir_q[C_HI:0]};
    srcs    = {reg_en, pcout, zhiout, zloout, hiout, loout, mdrout, inportout, cout};
    bus_or  = ({DW{reg_en}} & reg_bus) | ({DW{pcout}} & pc_q) | ({DW{zhiout}} & zhi_q)
            | ({DW{zloout}} & zlo_q) | ({DW{hiout}} & hi_q) | ({DW{loout}} & lo_q)
            | ({DW{mdrout}} & mdr_q) | ({DW{inportout}} & inport_data) | ({DW{cout}} & c_val);
    bus_conflict = $countones(srcs) > 1;
    bus     = bus_conflict ? '0 : bus_or;
  end
  // branch condition chosen by the low two bits of the Rb field
  always_comb begin
    c2   = c2_e'(ir_q[RB_LO +: 2]);
    cond = c2 == C2_ZERO ? bus == '0
         : c2 == C2_NZ   ? bus != '0
         : c2 == C2_POS  ? (!bus[DW-1] && bus != '0)
         : bus[DW-1];
  end
  // next values of the special registers; memory read data beats mdrin
  always_comb begin
    hi_d  = hiin ? bus : hi_q;
    lo_d  = loin ? bus : lo_q;
    y_d   = yin ? bus : y_q;
    zhi_d = zin ? alu_hi : zhi_q;
    zlo_d = zin ? alu_lo : zlo_q;
    pc_d  = pcin ? bus : inc_pc ? pc_q + DW'(1) : pc_q;
    ir_d  = irin ? bus : ir_q;
    mar_d = marin ? bus[AW-1:0] : mar_q;
    mdr_d = mdr_cap ? mem.mem_rdata : mdrin ? bus : mdr_q;
    out_d = outportin ? bus : out_q;
    con_d = conin ? cond : con_q;
  end
  // special register storage
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      out_q <= '0;
      con_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      out_q <= out_d;
      con_q <= con_d;
    end
  assign outport_data  = out_q;
  assign alu_a         = y_q;
  assign alu_b         = bus;
  assign ir            = ir_q;
  assign con_ff        = con_q;
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;
endmodule

// File: tb/tb_datapath_param.sv
// tb_datapath_param: directed self-checking bench for datapath_param
module tb_datapath_param;
  logic clock = 1'b0;
  logic clear;
  logic gra, grb, grc, rin, rout, baout;
  logic pcout, zhiout, zloout, hiout, loout, mdrout, inportout, cout;
  logic pcin, inc_pc, irin, yin, zin, hiin, loin, marin, mdrin, outportin, conin;
  logic mem_rd, mem_wr;
  logic [31:0] inport_data, outport_data, alu_a, alu_b, alu_lo, alu_hi, ir;
  logic busy, con_ff, bus_conflict;
  int n_assert = 0;
  int n_fail = 0;
  datapath_param_if #(.DW(32), .AW(9)) mem_if ();
  datapath_param #(.DW(32), .NREG(16), .AW(9)) dut (
    .clock(clock), .clear(clear),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .pcout(pcout), .zhiout(zhiout), .zloout(zloout), .hiout(hiout), .loout(loout),
    .mdrout(mdrout), .inportout(inportout), .cout(cout),
    .pcin(pcin), .inc_pc(inc_pc), .irin(irin), .yin(yin), .zin(zin), .hiin(hiin),
    .loin(loin), .marin(marin), .mdrin(mdrin), .outportin(outportin), .conin(conin),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .inport_data(inport_data), .outport_data(outport_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_lo(alu_lo), .alu_hi(alu_hi),
    .mem(mem_if), .busy(busy), .con_ff(con_ff), .ir(ir), .bus_conflict(bus_conflict)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic quiet();
    {gra, grb, grc, rin, rout, baout} = '0;
    {pcout, zhiout, zloout, hiout, loout, mdrout, inportout, cout} = '0;
    {pcin, inc_pc, irin, yin, zin, hiin, loin, marin, mdrin, outportin, conin} = '0;
    {mem_rd, mem_wr} = '0;
    mem_if.mem_ack = 1'b0;
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    quiet();
  endtask
  task automatic drive(input logic [31:0] v);
    inport_data = v;
    inportout = 1'b1;
  endtask
  initial begin
    quiet();
    clear = 1'b1;
    inport_data = '0;
    alu_lo = '0;
    alu_hi = '0;
    mem_if.mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outport", outport_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_ir", ir, 0);
    chk("rst_req", mem_if.mem_req, 0);
    chk("rst_we", mem_if.mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_con", con_ff, 0);
    chk("rst_wdata", mem_if.mem_wdata, 0);
    clear = 1'b0;
    drive(32'h1234); pcin = 1; step();
    pcout = 1; #1;
    chk("pc_out", alu_b, 32'h1234);
    chk("no_conflict", bus_conflict, 0);
    inportout = 1; #1;
    chk("conflict", bus_conflict, 1);
    chk("conflict_bus", alu_b, 0);
    quiet();
    drive(32'h0198_0000); irin = 1; step();
    chk("ir_load", ir, 32'h0198_0000);
    drive(32'hDEAD_BEEF); gra = 1; rin = 1; step();
    gra = 1; rout = 1; #1;
    chk("r3_read", alu_b, 32'hDEAD_BEEF);
    quiet();
    drive(32'h0018_0000); irin = 1; step();
    drive(32'h55); gra = 1; rin = 1; step();
    gra = 1; rout = 1; #1;
    chk("r0_rout", alu_b, 32'h55);
    quiet(); gra = 1; baout = 1; #1;
    chk("r0_baout", alu_b, 0);
    quiet(); grb = 1; rout = 1; #1;
    chk("rb_read", alu_b, 32'hDEAD_BEEF);
    quiet();
    drive(5); yin = 1; step();
    chk("y_load", alu_a, 5);
    drive(7); alu_lo = 12; alu_hi = 1; #1;
    chk("alu_b_bus", alu_b, 7);
    zin = 1; step();
    zloout = 1; #1;
    chk("zlo", alu_b, 12);
    quiet(); zhiout = 1; #1;
    chk("zhi", alu_b, 1);
    quiet();
    drive(32'hA5); hiin = 1; step();
    hiout = 1; #1;
    chk("hi", alu_b, 32'hA5);
    quiet();
    drive(32'h5A); loin = 1; step();
    loout = 1; #1;
    chk("lo", alu_b, 32'h5A);
    quiet();
    drive(32'h77); outportin = 1; step();
    chk("outport", outport_data, 32'h77);
    drive(32'h1F); marin = 1; step();
    mem_rd = 1; #1;
    chk("busy_pulse", busy, 1);
    step();
    chk("rd_req1", mem_if.mem_req, 1);
    chk("rd_we", mem_if.mem_we, 0);
    chk("rd_addr", {23'd0, mem_if.mem_addr}, 32'h1F);
    step();
    chk("rd_req2", mem_if.mem_req, 1);
    step();
    mem_if.mem_ack = 1; mem_if.mem_rdata = 32'hCAFE_F00D;
    drive(32'h1111); mdrin = 1; #1;
    chk("rd_req3", mem_if.mem_req, 1);
    step();
    chk("rd_req_drop", mem_if.mem_req, 0);
    chk("rd_busy_drop", busy, 0);
    mdrout = 1; #1;
    chk("rd_mdr", alu_b, 32'hCAFE_F00D);
    quiet();
    mem_if.mem_ack = 1; mem_if.mem_rdata = 32'h0BAD; step();
    chk("idle_ack_req", mem_if.mem_req, 0);
    chk("idle_ack_mdr", mem_if.mem_wdata, 32'hCAFE_F00D);
    drive(32'h2222); mdrin = 1; step();
    chk("mdrin", mem_if.mem_wdata, 32'h2222);
    mem_wr = 1; step();
    chk("wr_req", mem_if.mem_req, 1);
    chk("wr_we", mem_if.mem_we, 1);
    chk("wr_data", mem_if.mem_wdata, 32'h2222);
    mem_if.mem_ack = 1; step();
    chk("wr_done_req", mem_if.mem_req, 0);
    chk("wr_done_we", mem_if.mem_we, 0);
    mem_rd = 1; mem_wr = 1; step();
    chk("both_req", mem_if.mem_req, 1);
    chk("both_we", mem_if.mem_we, 0);
    mem_if.mem_rdata = 32'h3333; mem_if.mem_ack = 1; step();
    chk("both_rdata", mem_if.mem_wdata, 32'h3333);
    drive(32'h8000_0000); conin = 1; step();
    chk("con_neg", con_ff, 1);
    drive(1); conin = 1; step();
    chk("con_neg_pos", con_ff, 0);
    drive(32'h0010_0000); irin = 1; step();
    drive(0); conin = 1; step();
    chk("con_pos_zero", con_ff, 0);
    drive(1); conin = 1; step();
    chk("con_pos_one", con_ff, 1);
    drive(32'hFFFF_FFFF); pcin = 1; step();
    inc_pc = 1; step();
    pcout = 1; #1;
    chk("pc_wrap", alu_b, 0);
    quiet();
    drive(32'h40); pcin = 1; inc_pc = 1; step();
    pcout = 1; #1;
    chk("pc_prio", alu_b, 32'h40);
    quiet();
    mem_rd = 1; step();
    chk("abort_req_pre", mem_if.mem_req, 1);
    clear = 1; #1;
    chk("abort_req", mem_if.mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("clr_outport", outport_data, 0);
    chk("clr_alu_a", alu_a, 0);
    chk("clr_ir", ir, 0);
    chk("clr_con", con_ff, 0);
    mdrout = 1; #1;
    chk("clr_mdr", alu_b, 0);
    quiet();
    clear = 0;
    mem_rd = 1; step();
    chk("restart_req", mem_if.mem_req, 1);
    chk("restart_addr", {23'd0, mem_if.mem_addr}, 0);
    mem_if.mem_rdata = 32'h4444; mem_if.mem_ack = 1; step();
    chk("restart_done", mem_if.mem_req, 0);
    chk("restart_mdr", mem_if.mem_wdata, 32'h4444);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
